// File: rtl/xrv_fetch_q_if.sv
// Fetch-queue boundary: instruction bus on one side, decode on the other.
// master is the queue itself; slave is whatever drives the bus and decode sides.
interface xrv_fetch_q_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_data;
    logic        stalling;
    logic        jmp;
    logic [31:0] jmp_addr;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] inst_pc;
    logic        inst_is_compressed;

    modport master (
        output i_req, i_addr, inst, inst_valid, inst_pc, inst_is_compressed,
        input  i_gnt, i_rvalid, i_data, stalling, jmp, jmp_addr
    );

    modport slave (
        input  i_req, i_addr, inst, inst_valid, inst_pc, inst_is_compressed,
        output i_gnt, i_rvalid, i_data, stalling, jmp, jmp_addr
    );
endinterface

// File: rtl/xrv_fetch_q.sv
// Instruction prefetch queue: credit-limited word fetch into a small FIFO,
// with RVC/32-bit realignment (including word-straddling instructions) for decode.
module xrv_fetch_q #(
    parameter int          DEPTH    = 4,
    parameter int          MAX_OS   = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rstb,
    xrv_fetch_q_if.master bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0]   DEPTH_C  = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] MAX_OS_C = CW'(MAX_OS);

    logic [31:0]   fetchAddr_q, fetchAddr_d;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] osCnt_q, osCnt_d;
    logic [CW-1:0] discardCnt_q, discardCnt_d;
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [31:0]   mem_q [DEPTH];

    logic [31:0]   word0;
    logic [15:0]   word1Lo;
    logic [CW:0]   credit;
    logic          reqOk;
    logic          granted;
    logic          push;
    logic          pop;
    logic          consume;
    logic          isComp;
    logic [31:0]   alignedInst;
    logic [CW-1:0] wordsNeeded;
    logic          instValid;

    assign word0   = mem_q[rdPtr_q];
    assign word1Lo = mem_q[rdPtr_q + PW'(1)][15:0];

    // Words already buffered plus words still in flight bound what we may request.
    assign credit  = {1'b0, cnt_q} + {1'b0, osCnt_q};
    assign reqOk   = rstb && !bus.jmp && (credit < DEPTH_C) && (osCnt_q < MAX_OS_C);
    assign granted = reqOk && bus.i_gnt;
    assign push    = bus.i_rvalid && (discardCnt_q == '0) && !bus.jmp;

    always_comb begin
        isComp      = 1'b0;
        alignedInst = word0;
        wordsNeeded = CW'(1);
        if (!pc_q[1]) begin
            if (word0[1:0] != 2'b11) begin
                isComp      = 1'b1;
                alignedInst = {16'h0000, word0[15:0]};
            end
        end else if (word0[17:16] != 2'b11) begin
            isComp      = 1'b1;
            alignedInst = {16'h0000, word0[31:16]};
        end else begin
            alignedInst = {word1Lo, word0[31:16]};
            wordsNeeded = CW'(2);
        end
    end

    // The cnt != 0 term keeps valid clean while the unreset FIFO storage is still unknown.
    assign instValid = (cnt_q != '0) && (cnt_q >= wordsNeeded);
    assign consume   = instValid && !bus.stalling && !bus.jmp;
    assign pop       = consume && (pc_q[1] || !isComp);

    always_comb begin
        fetchAddr_d  = fetchAddr_q;
        pc_d         = pc_q;
        cnt_d        = cnt_q + CW'(push) - CW'(pop);
        osCnt_d      = osCnt_q + CW'(granted) - CW'(bus.i_rvalid);
        discardCnt_d = discardCnt_q;
        rdPtr_d      = rdPtr_q;
        wrPtr_d      = wrPtr_q;

        if (granted) begin
            fetchAddr_d = fetchAddr_q + 32'd4;
        end
        if (bus.i_rvalid && (discardCnt_q != '0)) begin
            discardCnt_d = discardCnt_q - CW'(1);
        end
        if (push) begin
            wrPtr_d = wrPtr_q + PW'(1);
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + PW'(1);
        end
        if (consume) begin
            pc_d = pc_q + (isComp ? 32'd2 : 32'd4);
        end

        // Redirect wins: everything still in flight becomes stale, including a response landing now.
        if (bus.jmp) begin
            cnt_d        = '0;
            rdPtr_d      = '0;
            wrPtr_d      = '0;
            pc_d         = bus.jmp_addr & 32'hFFFF_FFFE;
            fetchAddr_d  = bus.jmp_addr & 32'hFFFF_FFFC;
            discardCnt_d = osCnt_q - CW'(bus.i_rvalid);
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            fetchAddr_q  <= RESET_PC & 32'hFFFF_FFFC;
            pc_q         <= RESET_PC;
            cnt_q        <= '0;
            osCnt_q      <= '0;
            discardCnt_q <= '0;
            rdPtr_q      <= '0;
            wrPtr_q      <= '0;
        end else begin
            fetchAddr_q  <= fetchAddr_d;
            pc_q         <= pc_d;
            cnt_q        <= cnt_d;
            osCnt_q      <= osCnt_d;
            discardCnt_q <= discardCnt_d;
            rdPtr_q      <= rdPtr_d;
            wrPtr_q      <= wrPtr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wrPtr_q] <= bus.i_data;
        end
    end

    assign bus.i_req              = reqOk;
    assign bus.i_addr             = fetchAddr_q;
    assign bus.inst_valid         = instValid;
    assign bus.inst               = instValid ? alignedInst : 32'h0000_0000;
    assign bus.inst_pc            = pc_q;
    assign bus.inst_is_compressed = instValid && isComp;

endmodule
